// File: rtl/cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_rx
// Receive side of a four-phase req/ack clock-domain-crossing handshake.
// The asynchronous request level is synchronized into clk. The data word that
// accompanies it is captured and offered to a local consumer over valid/ready.
// The acknowledge is returned only after the consumer takes the word, so the
// consumer applies backpressure all the way back to the sender.
//
// Ports
//   clk        in   receive-domain clock
//   rst        in   asynchronous, active-high reset
//   req_in     in   request level from the sender (asynchronous to clk)
//   data_in    in   sender data, held stable while req_in is high and until
//                   the sender sees ack_out high
//   ack_out    out  acknowledge level back to the sender, straight from a flop
//   out_valid  out  a captured word is available
//   out_data   out  captured word; holds the last capture after acceptance
//   out_ready  in   consumer accepts when high together with out_valid
//   busy       out  high whenever the handshake FSM is not idle
//   proto_err  out  sticky: the sender dropped req_in before it was acked
//   rx_count   out  count of accepted words, wraps modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module cdc_handshake_rx #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned COUNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_in,
   input  logic [DATA_W-1:0]  data_in,
   output logic               ack_out,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   input  logic               out_ready,
   output logic               busy,
   output logic               proto_err,
   output logic [COUNT_W-1:0] rx_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_VALID = 2'd1,
      ST_ACK   = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // Request synchronizer. Only the last stage (req_s) feeds the logic.
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
      end
   end

   assign req_s = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Handshake FSM registers
   // ---------------------------------------------------------------------------
   state_e               state_q,  state_d;
   logic                 ack_q,    ack_d;
   logic                 valid_q,  valid_d;
   logic [DATA_W-1:0]    data_q,   data_d;
   logic                 busy_q,   busy_d;
   logic                 err_q,    err_d;
   logic [COUNT_W-1:0]   count_q,  count_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic.
   // data_in is sampled directly: the sender holds it stable for at least
   // SYNC_STAGES cycles before req_s can rise, so it is quiet at capture time.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      valid_d = valid_q;
      data_d  = data_q;
      err_d   = err_q;
      count_d = count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               data_d  = data_in;
               valid_d = 1'b1;
               state_d = ST_VALID;
            end
         end

         ST_VALID: begin
            // Request withdrawn before ack: flag it, but still finish the word.
            if (!req_s) begin
               err_d = 1'b1;
            end
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               ack_d   = 1'b1;
               count_d = count_q + COUNT_W'(1);
               state_d = ST_ACK;
            end
         end

         ST_ACK: begin
            // Waiting for the request to drop guarantees one word per level.
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            ack_d   = 1'b0;
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign ack_out   = ack_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign busy      = busy_q;
   assign proto_err = err_q;
   assign rx_count  = count_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// Bench for cdc_handshake_rx. Two instances share all stimulus: the default
// configuration and one with a 4-bit counter to exercise wrap-around.
// A behavioural model of the receiver rules is checked every cycle, and a
// queue of sent words checks order/data of every accepted word.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_rx;

   localparam int unsigned DW = 32;
   localparam int unsigned SS = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_in;
   logic [DW-1:0] data_in;
   logic          out_ready;

   logic          ack_out,  out_valid,  busy,  proto_err;
   logic [DW-1:0] out_data;
   logic [15:0]   rx_count;

   logic          ack_out4, out_valid4, busy4, proto_err4;
   logic [DW-1:0] out_data4;
   logic [3:0]    rx_count4;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   cdc_handshake_rx #(.DATA_W(DW), .SYNC_STAGES(SS), .COUNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
      .ack_out(ack_out), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .busy(busy), .proto_err(proto_err),
      .rx_count(rx_count)
   );

   cdc_handshake_rx #(.DATA_W(DW), .SYNC_STAGES(SS), .COUNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
      .ack_out(ack_out4), .out_valid(out_valid4), .out_data(out_data4),
      .out_ready(out_ready), .busy(busy4), .proto_err(proto_err4),
      .rx_count(rx_count4)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: req seen SS edges late; one word per request level;
   // word offered until taken; ack held until the delayed request drops.
   // ---------------------------------------------------------------------------
   logic          req_hist [SS];
   logic          m_offer;     // word being offered to the consumer
   logic          m_acked;     // ack raised, waiting for request release
   logic          m_err;
   logic [DW-1:0] m_word;
   int            m_taken;     // total words accepted since reset

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(SS); i++) req_hist[i] <= 1'b0;
         m_offer <= 1'b0;
         m_acked <= 1'b0;
         m_err   <= 1'b0;
         m_word  <= '0;
         m_taken <= 0;
      end else begin
         req_hist[0] <= req_in;
         for (int i = 1; i < int'(SS); i++) req_hist[i] <= req_hist[i-1];
         if (!m_offer && !m_acked) begin
            if (req_hist[SS-1]) begin
               m_offer <= 1'b1;
               m_word  <= data_in;
            end
         end else if (m_offer) begin
            if (!req_hist[SS-1]) m_err <= 1'b1;
            if (out_ready) begin
               m_offer <= 1'b0;
               m_acked <= 1'b1;
               m_taken <= m_taken + 1;
            end
         end else if (!req_hist[SS-1]) begin
            m_acked <= 1'b0;
         end
      end
   end

   // Per-cycle compare, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("ack",       64'(ack_out),   64'(m_acked));
         chk("valid",     64'(out_valid), 64'(m_offer));
         chk("data",      64'(out_data),  64'(m_word));
         chk("busy",      64'(busy),      64'(m_offer | m_acked));
         chk("proto_err", 64'(proto_err), 64'(m_err));
         chk("rx_count",  64'(rx_count),  64'(m_taken % 65536));
         chk("ack4",      64'(ack_out4),  64'(m_acked));
         chk("valid4",    64'(out_valid4),64'(m_offer));
         chk("data4",     64'(out_data4), 64'(m_word));
         chk("rx_count4", 64'(rx_count4), 64'(m_taken % 16));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("accept_unexpected", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               chk("accept_order", 64'(out_data), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_in = 1'b0;
      tick();
      tick();
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic wait_ack(input logic lvl);
      int n = 0;
      while (ack_out !== lvl && n < 200) begin
         tick();
         n++;
      end
      chk("ack_wait", 64'(ack_out), 64'(lvl));
   endtask

   task automatic send(input logic [DW-1:0] w);
      data_in = w;
      req_in  = 1'b1;
      exp_q.push_back(w);
      wait_ack(1'b1);
      req_in = 1'b0;
      wait_ack(1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] w;
      rst = 1'b1;
      req_in = 1'b0;
      data_in = '0;
      out_ready = 1'b0;
      #3;
      // Reset values
      chk("rst_ack",   64'(ack_out),   64'h0);
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_data",  64'(out_data),  64'h0);
      chk("rst_busy",  64'(busy),      64'h0);
      chk("rst_err",   64'(proto_err), 64'h0);
      chk("rst_count", 64'(rx_count),  64'h0);
      do_reset();

      // Single transfer, out_ready high
      out_ready = 1'b1;
      data_in = 32'hA5A5_0001;
      req_in = 1'b1;
      exp_q.push_back(32'hA5A5_0001);
      tick(); chk("st_valid_e1", 64'(out_valid), 64'h0);
      tick(); chk("st_valid_e2", 64'(out_valid), 64'h0);
      tick(); chk("st_valid_e3", 64'(out_valid), 64'h1);
              chk("st_data_e3",  64'(out_data),  64'hA5A5_0001);
              chk("st_ack_e3",   64'(ack_out),   64'h0);
      tick(); chk("st_valid_e4", 64'(out_valid), 64'h0);
              chk("st_ack_e4",   64'(ack_out),   64'h1);
      req_in = 1'b0;
      tick(); chk("st_ack_r1",   64'(ack_out),   64'h1);
      tick(); chk("st_ack_r2",   64'(ack_out),   64'h1);
      tick(); chk("st_ack_r3",   64'(ack_out),   64'h0);
              chk("st_count",    64'(rx_count),  64'h1);
              chk("st_data_hold",64'(out_data),  64'hA5A5_0001);

      // Backpressure
      do_reset();
      out_ready = 1'b0;
      data_in = 32'h1234_5678;
      req_in = 1'b1;
      exp_q.push_back(32'h1234_5678);
      tick(); tick(); tick();
      chk("bp_valid", 64'(out_valid), 64'h1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("bp_hold_valid", 64'(out_valid), 64'h1);
         chk("bp_hold_ack",   64'(ack_out),   64'h0);
         chk("bp_hold_data",  64'(out_data),  64'h1234_5678);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_ack",   64'(ack_out),   64'h1);
      chk("bp_valid_clr", 64'(out_valid), 64'h0);
      req_in = 1'b0;
      wait_ack(1'b0);

      // Back-to-back random words
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         w = $urandom;
         send(w);
      end
      tick();
      chk("b2b_count", 64'(rx_count),    64'd100);
      chk("b2b_err",   64'(proto_err),   64'h0);
      chk("b2b_drain", 64'(exp_q.size()),64'h0);

      // Protocol error: request withdrawn while the word is still offered
      do_reset();
      out_ready = 1'b0;
      data_in = 32'hDEAD_BEEF;
      req_in = 1'b1;
      exp_q.push_back(32'hDEAD_BEEF);
      tick(); tick(); tick();
      chk("pe_valid", 64'(out_valid), 64'h1);
      req_in = 1'b0;
      tick(); tick(); tick();
      chk("pe_err", 64'(proto_err), 64'h1);
      out_ready = 1'b1;
      tick();
      chk("pe_ack_hi",  64'(ack_out),   64'h1);
      chk("pe_valid_lo",64'(out_valid), 64'h0);
      tick();
      chk("pe_ack_lo",  64'(ack_out),   64'h0);
      chk("pe_idle",    64'(busy),      64'h0);
      chk("pe_sticky",  64'(proto_err), 64'h1);
      chk("pe_count",   64'(rx_count),  64'h1);

      // Reset in the ACK state with the request still high
      do_reset();
      out_ready = 1'b1;
      data_in = 32'h0BAD_F00D;
      req_in = 1'b1;
      exp_q.push_back(32'h0BAD_F00D);
      tick(); tick(); tick(); tick();
      chk("mr_ack_pre", 64'(ack_out), 64'h1);
      #1 rst = 1'b1;
      #1;
      chk("mr_ack",   64'(ack_out),   64'h0);
      chk("mr_valid", 64'(out_valid), 64'h0);
      chk("mr_data",  64'(out_data),  64'h0);
      chk("mr_busy",  64'(busy),      64'h0);
      chk("mr_err",   64'(proto_err), 64'h0);
      chk("mr_count", 64'(rx_count),  64'h0);
      exp_q.delete();
      exp_q.push_back(32'h0BAD_F00D);
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("mr_valid_e2", 64'(out_valid), 64'h0);
      tick();
      chk("mr_valid_e3", 64'(out_valid), 64'h1);
      chk("mr_data_e3",  64'(out_data),  64'h0BAD_F00D);
      tick();
      chk("mr_ack_again", 64'(ack_out),  64'h1);
      chk("mr_count_1",   64'(rx_count), 64'h1);
      req_in = 1'b0;
      wait_ack(1'b0);

      // Counter wrap on the 4-bit instance
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send(32'hC000_0000 | 32'(i));
      end
      tick();
      chk("wrap_count4", 64'(rx_count4), 64'h1);
      chk("wrap_count",  64'(rx_count),  64'd17);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
